// File: rtl/adc_result_fifo.sv
// ADC conversion-result FIFO.
// Takes an asynchronous conversion-finished strobe from the ADC core and resynchronises it.
// Stores one result per strobe rising edge in a show-ahead FIFO.
// Reports fill status, a sticky overflow flag and a registered interrupt.
module adc_result_fifo #(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 8,
    parameter int IRQ_THRESHOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     conv_finished_in,
    input  logic [WIDTH-1:0]         result_in,
    input  logic                     rd_en_in,
    input  logic                     clear_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid_out,
    output logic [$clog2(DEPTH):0]   fill_level_out,
    output logic                     full_out,
    output logic                     empty_out,
    output logic                     overflow_out,
    output logic                     irq_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_L = DEPTH[AW:0];
    localparam logic [AW:0]   THR_L   = IRQ_THRESHOLD[AW:0];
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             sync1;
    logic             sync2;
    logic             hist;
    logic             wr_pulse;
    logic             do_pop;
    logic             do_wr;
    logic             is_full;
    logic             is_empty;

    // Strobe synchroniser and edge history; preset to 1 so a strobe that is
    // already high when reset releases is not mistaken for a new rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= conv_finished_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Pop and push qualification; a full FIFO accepts a write only when the
    // same cycle pops, and clear discards everything in flight.
    always_comb begin
        is_full  = (count == DEPTH_L);
        is_empty = (count == '0);
        wr_pulse = sync2 & ~hist;
        do_pop   = rd_en_in & ~is_empty & ~clear_in;
        do_wr    = wr_pulse & (~is_full | do_pop) & ~clear_in;
    end

    // Result storage, intentionally without reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= result_in;
        end
    end

    // Pointers, fill level and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_out <= 1'b0;
        end else if (clear_in) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_wr && !do_pop) begin
                count <= count + CNT_ONE;
            end else if (do_pop && !do_wr) begin
                count <= count - CNT_ONE;
            end
            if (wr_pulse && is_full && !do_pop) begin
                overflow_out <= 1'b1;
            end
        end
    end

    // Interrupt registered from the current fill level and overflow state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_out <= 1'b0;
        end else begin
            irq_out <= (count >= THR_L) | overflow_out;
        end
    end

    // Status outputs, all derived from the same fill-level register.
    always_comb begin
        fill_level_out = count;
        full_out       = is_full;
        empty_out      = is_empty;
        data_valid_out = ~is_empty;
        data_out       = is_empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: tb/tb_adc_result_fifo.sv
// Directed bench for adc_result_fifo (WIDTH=16, DEPTH=8, IRQ_THRESHOLD=4).
module tb_adc_result_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conv_finished_in = 1'b0;
    logic [15:0] result_in = '0;
    logic        rd_en_in = 1'b0;
    logic        clear_in = 1'b0;
    logic [15:0] data_out;
    logic        data_valid_out;
    logic [3:0]  fill_level_out;
    logic        full_out;
    logic        empty_out;
    logic        overflow_out;
    logic        irq_out;

    int checks = 0;
    int errors = 0;

    adc_result_fifo #(.WIDTH(16), .DEPTH(8), .IRQ_THRESHOLD(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .conv_finished_in (conv_finished_in),
        .result_in        (result_in),
        .rd_en_in         (rd_en_in),
        .clear_in         (clear_in),
        .data_out         (data_out),
        .data_valid_out   (data_valid_out),
        .fill_level_out   (fill_level_out),
        .full_out         (full_out),
        .empty_out        (empty_out),
        .overflow_out     (overflow_out),
        .irq_out          (irq_out)
    );

    always #5 clk = ~clk;

    // Strobe rises on a falling edge, stays high for hold cycles, then the
    // bench waits long enough for the write to land.
    task automatic strobe(input logic [15:0] v, input int hold);
        @(negedge clk);
        result_in = v;
        conv_finished_in = 1'b1;
        repeat (hold) @(negedge clk);
        conv_finished_in = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic pop();
        rd_en_in = 1'b1;
        @(negedge clk);
        rd_en_in = 1'b0;
    endtask

    task automatic test_reset();
        int found;
        #1;
        checks++; if (fill_level_out !== 4'd0) begin errors++; $display("FAIL rst_fill got %0d exp 0", fill_level_out); end
        checks++; if (empty_out !== 1'b1 || full_out !== 1'b0 || data_valid_out !== 1'b0) begin errors++; $display("FAIL rst_flags got e%b f%b v%b exp e1 f0 v0", empty_out, full_out, data_valid_out); end
        checks++; if (data_out !== 16'h0 || overflow_out !== 1'b0 || irq_out !== 1'b0) begin errors++; $display("FAIL rst_out got d%h o%b i%b exp d0000 o0 i0", data_out, overflow_out, irq_out); end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        result_in = 16'h0ABC;
        conv_finished_in = 1'b1;
        found = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) conv_finished_in = 1'b0;
            if (data_valid_out && found == 0) found = i;
        end
        checks++; if (found < 3) begin errors++; $display("FAIL first_write_latency got %0d exp 3..4", found); end
        checks++; if (data_out !== 16'h0ABC || fill_level_out !== 4'd1) begin errors++; $display("FAIL first_write got d%h n%0d exp d0abc n1", data_out, fill_level_out); end
        repeat (2) @(negedge clk);
        pop();
        checks++; if (empty_out !== 1'b1 || data_out !== 16'h0) begin errors++; $display("FAIL first_read got e%b d%h exp e1 d0000", empty_out, data_out); end
        pop();
        checks++; if (fill_level_out !== 4'd0 || overflow_out !== 1'b0) begin errors++; $display("FAIL empty_pop got n%0d o%b exp n0 o0", fill_level_out, overflow_out); end
        strobe(16'h0BCD, 1);
        checks++; if (data_out !== 16'h0BCD || fill_level_out !== 4'd1) begin errors++; $display("FAIL after_empty_pop got d%h n%0d exp d0bcd n1", data_out, fill_level_out); end
        pop();
    endtask

    task automatic test_threshold();
        for (int v = 1; v <= 3; v++) strobe(16'(v), 1);
        checks++; if (irq_out !== 1'b0 || fill_level_out !== 4'd3) begin errors++; $display("FAIL thr_below got i%b n%0d exp i0 n3", irq_out, fill_level_out); end
        @(negedge clk);
        result_in = 16'd4;
        conv_finished_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) conv_finished_in = 1'b0;
            if (i == 3) begin
                checks++; if (fill_level_out !== 4'd4 || irq_out !== 1'b0) begin errors++; $display("FAIL thr_edge got n%0d i%b exp n4 i0", fill_level_out, irq_out); end
            end
            if (i == 4) begin
                checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL thr_lag got i%b exp i1", irq_out); end
            end
        end
        repeat (2) @(negedge clk);
        for (int v = 5; v <= 8; v++) strobe(16'(v), 1);
        checks++; if (full_out !== 1'b1 || fill_level_out !== 4'd8 || irq_out !== 1'b1) begin errors++; $display("FAIL thr_full got f%b n%0d i%b exp f1 n8 i1", full_out, fill_level_out, irq_out); end
        for (int v = 1; v <= 8; v++) begin
            checks++; if (data_out !== 16'(v)) begin errors++; $display("FAIL thr_order got %h exp %h", data_out, 16'(v)); end
            pop();
        end
        checks++; if (empty_out !== 1'b1) begin errors++; $display("FAIL thr_drain got e%b exp e1", empty_out); end
    endtask

    task automatic test_overflow_clear();
        for (int v = 1; v <= 8; v++) strobe(16'(v), 1);
        strobe(16'h0099, 1);
        checks++; if (overflow_out !== 1'b1 || irq_out !== 1'b1 || fill_level_out !== 4'd8) begin errors++; $display("FAIL ovf_set got o%b i%b n%0d exp o1 i1 n8", overflow_out, irq_out, fill_level_out); end
        for (int v = 1; v <= 8; v++) begin
            checks++; if (data_out !== 16'(v)) begin errors++; $display("FAIL ovf_contents got %h exp %h", data_out, 16'(v)); end
            pop();
        end
        checks++; if (overflow_out !== 1'b1 || irq_out !== 1'b1) begin errors++; $display("FAIL ovf_sticky got o%b i%b exp o1 i1", overflow_out, irq_out); end
        strobe(16'h0011, 1);
        strobe(16'h0022, 1);
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        checks++; if (fill_level_out !== 4'd0 || empty_out !== 1'b1 || data_out !== 16'h0 || overflow_out !== 1'b0) begin errors++; $display("FAIL clear got n%0d e%b d%h o%b exp n0 e1 d0000 o0", fill_level_out, empty_out, data_out, overflow_out); end
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL clear_irq_lag got i%b exp i1", irq_out); end
        @(negedge clk);
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL clear_irq got i%b exp i0", irq_out); end
        strobe(16'h0033, 1);
        checks++; if (data_out !== 16'h0033 || fill_level_out !== 4'd1) begin errors++; $display("FAIL after_clear got d%h n%0d exp d0033 n1", data_out, fill_level_out); end
        pop();
    endtask

    task automatic test_read_write_same_cycle();
        @(negedge clk);
        result_in = 16'h0066;
        conv_finished_in = 1'b1;
        @(negedge clk);
        conv_finished_in = 1'b0;
        @(negedge clk);
        rd_en_in = 1'b1;
        @(negedge clk);
        rd_en_in = 1'b0;
        checks++; if (fill_level_out !== 4'd1 || data_out !== 16'h0066) begin errors++; $display("FAIL rw_empty got n%0d d%h exp n1 d0066", fill_level_out, data_out); end
        repeat (3) @(negedge clk);
        pop();
        for (int v = 0; v < 8; v++) strobe(16'h0010 + 16'(v), 1);
        @(negedge clk);
        result_in = 16'h0055;
        conv_finished_in = 1'b1;
        @(negedge clk);
        conv_finished_in = 1'b0;
        @(negedge clk);
        rd_en_in = 1'b1;
        @(negedge clk);
        rd_en_in = 1'b0;
        checks++; if (fill_level_out !== 4'd8 || overflow_out !== 1'b0 || full_out !== 1'b1) begin errors++; $display("FAIL rw_full got n%0d o%b f%b exp n8 o0 f1", fill_level_out, overflow_out, full_out); end
        repeat (3) @(negedge clk);
        for (int v = 1; v < 8; v++) begin
            checks++; if (data_out !== 16'h0010 + 16'(v)) begin errors++; $display("FAIL rw_order got %h exp %h", data_out, 16'h0010 + 16'(v)); end
            pop();
        end
        checks++; if (data_out !== 16'h0055) begin errors++; $display("FAIL rw_last got %h exp 0055", data_out); end
        pop();
        checks++; if (empty_out !== 1'b1 || overflow_out !== 1'b0) begin errors++; $display("FAIL rw_drain got e%b o%b exp e1 o0", empty_out, overflow_out); end
    endtask

    task automatic test_strobe_hold();
        strobe(16'h0077, 20);
        checks++; if (fill_level_out !== 4'd1 || data_out !== 16'h0077) begin errors++; $display("FAIL hold got n%0d d%h exp n1 d0077", fill_level_out, data_out); end
        pop();
    endtask

    task automatic test_mid_reset();
        strobe(16'h0001, 1);
        strobe(16'h0002, 1);
        @(negedge clk);
        result_in = 16'h0003;
        conv_finished_in = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (fill_level_out !== 4'd0 || empty_out !== 1'b1 || data_out !== 16'h0 || data_valid_out !== 1'b0) begin errors++; $display("FAIL mid_rst got n%0d e%b d%h v%b exp n0 e1 d0000 v0", fill_level_out, empty_out, data_out, data_valid_out); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        conv_finished_in = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (fill_level_out !== 4'd0 || empty_out !== 1'b1) begin errors++; $display("FAIL rst_release_strobe got n%0d e%b exp n0 e1", fill_level_out, empty_out); end
    endtask

    task automatic test_wrap();
        logic [15:0] q[$];
        logic [15:0] exp_v;
        for (int i = 0; i < 24; i++) begin
            if (q.size() == 8 || (q.size() > 0 && $urandom_range(0, 1) == 1)) begin
                exp_v = q.pop_front();
                checks++; if (data_out !== exp_v) begin errors++; $display("FAIL wrap_data got %h exp %h", data_out, exp_v); end
                pop();
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            strobe(16'hA000 + 16'(i), 1);
            q.push_back(16'hA000 + 16'(i));
            checks++; if (fill_level_out !== 4'(q.size())) begin errors++; $display("FAIL wrap_fill got %0d exp %0d", fill_level_out, q.size()); end
        end
        while (q.size() > 0) begin
            exp_v = q.pop_front();
            checks++; if (data_out !== exp_v) begin errors++; $display("FAIL wrap_drain got %h exp %h", data_out, exp_v); end
            pop();
        end
        checks++; if (empty_out !== 1'b1 || overflow_out !== 1'b0) begin errors++; $display("FAIL wrap_end got e%b o%b exp e1 o0", empty_out, overflow_out); end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_overflow_clear();
        test_read_write_same_cycle();
        test_strobe_hold();
        test_mid_reset();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_result_fifo.md
ADC_RESULT_FIFO -- requirements
Module: adc_result_fifo

Interface
REQ-001 Parameter WIDTH, default 16, bit width of a stored conversion result.
REQ-002 Parameter DEPTH, default 8, number of FIFO entries; power of two, 2..64.
REQ-003 Parameter IRQ_THRESHOLD, default 4, fill level at or above which irq_out asserts; range 1..DEPTH.
REQ-004 clk  input  1  digital clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 conv_finished_in  input  1  conversion-finished strobe from the ADC digital core; asynchronous to clk.
REQ-007 result_in  input  WIDTH  conversion result from the ADC digital core; held stable from the strobe rising edge until at least 4 clk cycles later.
REQ-008 rd_en_in  input  1  pop request from the consumer; synchronous to clk.
REQ-009 clear_in  input  1  synchronous flush of FIFO contents and overflow flag.
REQ-010 data_out  output  WIDTH  head entry (show-ahead); zero when empty.
REQ-011 data_valid_out  output  1  high when the FIFO holds at least one entry.
REQ-012 fill_level_out  output  log2(DEPTH)+1  number of stored entries, 0..DEPTH.
REQ-013 full_out  output  1  high when fill level equals DEPTH.
REQ-014 empty_out  output  1  high when fill level is 0.
REQ-015 overflow_out  output  1  sticky flag: at least one result was dropped.
REQ-016 irq_out  output  1  registered interrupt: fill level >= IRQ_THRESHOLD, or overflow_out high.

Function
REQ-017 conv_finished_in SHALL pass through a 2-flop synchronizer followed by a history flop; a write pulse SHALL be generated on the cycle in which synchronized=1 and history=0.
REQ-018 The write pulse SHALL occur on the 3rd rising clk edge after the strobe rises, or on the 4th depending on metastability resolution; result_in SHALL be sampled on the write-pulse cycle.
REQ-019 A strobe held high for many cycles SHALL produce exactly one write; a new write SHALL require the strobe to go low and then high again.
REQ-020 On a write pulse with the FIFO not full, result_in SHALL be stored at the write pointer, and the write pointer SHALL increment modulo DEPTH.
REQ-021 On a write pulse with the FIFO full and no pop in the same cycle, the result SHALL be dropped, contents SHALL be unchanged, and overflow_out SHALL be set on the next edge.
REQ-022 rd_en_in with data_valid_out high SHALL advance the read pointer modulo DEPTH; the next entry, or zero, SHALL appear on data_out after the following edge.
REQ-023 rd_en_in with the FIFO empty SHALL be ignored, with no pointer change and no error flag.
REQ-024 A simultaneous write and pop with the FIFO full SHALL accept the write; the fill level SHALL stay at DEPTH and overflow_out SHALL not be set.
REQ-025 A simultaneous write and pop with the FIFO empty SHALL ignore the pop and accept the write, giving fill level 1.
REQ-026 A simultaneous write and pop otherwise SHALL leave the fill level unchanged.
REQ-027 clear_in SHALL take priority over write and pop in the same cycle: pointers and fill level SHALL go to 0, overflow_out SHALL go to 0, and the concurrent write SHALL be discarded.
REQ-028 overflow_out SHALL clear only via clear_in or rst.
REQ-029 fill_level_out, full_out, empty_out, and data_valid_out SHALL be consistent within the same cycle.
REQ-030 irq_out SHALL be registered, lagging the fill-level/overflow condition by one cycle.
REQ-031 Storage contents SHALL not be reset; data_out SHALL be forced to zero while empty.

Reset
REQ-032 While rst is high, asynchronously: pointers=0, fill_level_out=0, empty_out=1, full_out=0, data_valid_out=0, data_out=0, overflow_out=0, irq_out=0.
REQ-033 Synchronizer and history flops SHALL reset to 1, so that a strobe already high at reset release does not cause a write.
REQ-034 Reset asserted mid-operation SHALL discard all entries and any in-flight strobe without a write.

Verification
REQ-035 Reset scenario: release rst, single 1-cycle strobe with result_in=0x0ABC. Required response: within 4 edges data_valid_out=1, data_out=0x0ABC, fill_level_out=1; one rd_en_in -> empty_out=1, data_out=0.
REQ-036 Threshold scenario: 8 strobes with values 1..8 and no reads. Required response: full_out=1, fill_level_out=8, irq_out=1 one cycle after fill reaches 4; reads return 1..8 in order.
REQ-037 Overflow scenario: 9th strobe while full. Required response: overflow_out=1, irq_out=1, contents still 1..8; then clear_in -> fill_level_out=0, overflow_out=0, irq_out=0 one cycle later.
REQ-038 Full read+write scenario: full FIFO, rd_en_in aligned to the write-pulse cycle with value 0x0055. Required response: fill_level_out stays 8, overflow_out=0, 0x0055 read out last.
REQ-039 Strobe-hold scenario: strobe held high 20 cycles. Required response: exactly one entry written.
REQ-040 Mid-burst reset scenario: strobe high at the moment rst deasserts. Required response: no entry is written.
REQ-041 Wrap scenario: 3*DEPTH interleaved writes and reads at random spacing. Required response: FIFO order matches a scoreboard model and pointers wrap with no loss.
